// File: rtl/dwc_downconv_wr_addr_split_if.sv
// Narrow-side AXI write-address channel of the down-converter.
// The master modport drives the AW payload and VALID; the slave modport drives READY.
interface dwc_downconv_wr_addr_split_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic [ID_WIDTH-1:0]   AWID;

    modport master (
        output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
        input  AWREADY
    );

    modport slave (
        input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
        output AWREADY
    );
endinterface

// File: rtl/dwc_downconv_wr_addr_split.sv
// Down-converter write-address split: re-issues one held wide AW command as narrow slave bursts.
// Optional DWC_DOWNCONV_WR_BCNT_EN adds a per-command burst-count push for the B merge path.
//
// state | meaning
// IDLE  | waiting for a held command; captures hold_* on entry to LOAD
// LOAD  | one cycle: derive ratio, total beats, base and first chunk payload
// ISSUE | SLAVE.AWVALID high; advance chunk on every handshake
module dwc_downconv_wr_addr_split #(
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 1,
    parameter int SLV_SIZE_MAX  = 2,
    parameter int MSTR_SIZE_MAX = 3
) (
    input  logic                  ACLK,
    input  logic                  sysReset,
    input  logic                  hold_valid,
    input  logic [ADDR_WIDTH-1:0] hold_addr,
    input  logic [7:0]            hold_len,
    input  logic [2:0]            hold_size,
    input  logic [1:0]            hold_burst,
    input  logic [ID_WIDTH-1:0]   hold_id,
    output logic                  hold_get_next_data,
    output logic                  split_err,
`ifdef DWC_DOWNCONV_WR_BCNT_EN
    output logic                  bcnt_push,
    output logic [8:0]            bcnt_data,
`endif
    dwc_downconv_wr_addr_split_if.master SLAVE
);
    localparam int TB_W = 9 + MSTR_SIZE_MAX - SLV_SIZE_MAX;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] CHUNK_STRIDE = ADDR_WIDTH'(256 << SLV_SIZE_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;
    state_t state, stateNext;

    logic [ADDR_WIDTH-1:0] cmdAddr, awAddr, baseAddr;
    logic [7:0]            cmdLen, awLen;
    logic [2:0]            cmdSize, awSize, effSize, ratioLog;
    logic [1:0]            cmdBurst, awBurst;
    logic [ID_WIDTH-1:0]   cmdId;
    logic [TB_W-1:0]       remaining, totalBeats, beatsPerMstr;
    logic [TB_W-1:0]       chunkSrc, chunkIncr, chunk;
    logic                  convert, lastChunk, awValid, getNext, splitErr;

    // Sizes above the master bus width are illegal; clamp so the beat count cannot overflow.
    assign effSize      = (cmdSize > 3'(MSTR_SIZE_MAX)) ? 3'(MSTR_SIZE_MAX) : cmdSize;
    assign ratioLog     = (effSize > 3'(SLV_SIZE_MAX)) ? effSize - 3'(SLV_SIZE_MAX) : 3'd0;
    assign convert      = (ratioLog != 3'd0);
    assign totalBeats   = TB_W'({1'b0, cmdLen} + 9'd1) << ratioLog;
    assign beatsPerMstr = TB_W'(1) << ratioLog;
    assign baseAddr     = cmdAddr & ~((ADDR_WIDTH'(1) << effSize) - ADDR_WIDTH'(1));

    // Size of the chunk being loaded: first chunk in LOAD, following chunk in ISSUE.
    assign chunkSrc  = (state == LOAD) ? totalBeats : remaining;
    assign chunkIncr = (chunkSrc > TB_W'(256)) ? TB_W'(256) : chunkSrc;
    assign chunk     = (cmdBurst == BURST_FIXED) ? beatsPerMstr : chunkIncr;
    assign lastChunk = (remaining == '0);

    always_ff @(posedge ACLK or posedge sysReset) begin
        if (sysReset) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        awValid   = 1'b0;
        getNext   = 1'b0;
        splitErr  = 1'b0;
        case (state)
            IDLE: if (hold_valid) stateNext = LOAD;
            LOAD: begin
                stateNext = ISSUE;
                splitErr  = convert && (cmdBurst == BURST_WRAP);
            end
            ISSUE: begin
                awValid = 1'b1;
                if (SLAVE.AWREADY && lastChunk) begin
                    getNext   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge sysReset) begin
        if (sysReset) begin
            cmdAddr   <= '0;
            cmdLen    <= '0;
            cmdSize   <= '0;
            cmdBurst  <= '0;
            cmdId     <= '0;
            awAddr    <= '0;
            awLen     <= '0;
            awSize    <= '0;
            awBurst   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: if (hold_valid) begin
                    cmdAddr  <= hold_addr;
                    cmdLen   <= hold_len;
                    cmdSize  <= hold_size;
                    cmdBurst <= hold_burst;
                    cmdId    <= hold_id;
                end
                LOAD: if (!convert) begin
                    awAddr    <= cmdAddr;
                    awLen     <= cmdLen;
                    awSize    <= cmdSize;
                    awBurst   <= cmdBurst;
                    remaining <= '0;
                end else begin
                    awAddr    <= baseAddr;
                    awLen     <= 8'(chunk - TB_W'(1));
                    awSize    <= 3'(SLV_SIZE_MAX);
                    awBurst   <= BURST_INCR;
                    remaining <= totalBeats - chunk;
                end
                ISSUE: if (SLAVE.AWREADY && !lastChunk) begin
                    awLen     <= 8'(chunk - TB_W'(1));
                    remaining <= remaining - chunk;
                    if (cmdBurst != BURST_FIXED) awAddr <= awAddr + CHUNK_STRIDE;
                end
                default: ;
            endcase
        end
    end

`ifdef DWC_DOWNCONV_WR_BCNT_EN
    logic [8:0] burstCnt;

    always_ff @(posedge ACLK or posedge sysReset) begin
        if (sysReset)                               burstCnt <= '0;
        else if (state == LOAD)                     burstCnt <= '0;
        else if (state == ISSUE && SLAVE.AWREADY)   burstCnt <= burstCnt + 9'd1;
    end

    assign bcnt_push = getNext;
    assign bcnt_data = getNext ? burstCnt + 9'd1 : 9'd0;
`endif

    assign hold_get_next_data = getNext;
    assign split_err          = splitErr;
    assign SLAVE.AWVALID      = awValid;
    assign SLAVE.AWADDR       = awAddr;
    assign SLAVE.AWLEN        = awLen;
    assign SLAVE.AWSIZE       = awSize;
    assign SLAVE.AWBURST      = awBurst;
    assign SLAVE.AWID         = cmdId;
endmodule

// File: tb/tb_dwc_downconv_wr_addr_split.sv
// Scoreboard bench for dwc_downconv_wr_addr_split: expected slave AW bursts are queued per command
// and compared at each AW handshake; also covers stalls, split_err and reset mid-burst.
module tb_dwc_downconv_wr_addr_split;
    localparam int ADDR_WIDTH = 32;
    localparam int ID_WIDTH   = 1;

    logic        ACLK = 1'b0;
    logic        sysReset = 1'b1;
    logic        hold_valid = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [7:0]  hold_len = '0;
    logic [2:0]  hold_size = '0;
    logic [1:0]  hold_burst = '0;
    logic        hold_id = 1'b0;
    logic        hold_get_next_data;
    logic        split_err;
`ifdef DWC_DOWNCONV_WR_BCNT_EN
    logic        bcnt_push;
    logic [8:0]  bcnt_data;
`endif

    dwc_downconv_wr_addr_split_if #(.ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)) slvAw ();

    dwc_downconv_wr_addr_split #(
        .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH), .SLV_SIZE_MAX(2), .MSTR_SIZE_MAX(3)
    ) dut (
        .ACLK(ACLK),
        .sysReset(sysReset),
        .hold_valid(hold_valid),
        .hold_addr(hold_addr),
        .hold_len(hold_len),
        .hold_size(hold_size),
        .hold_burst(hold_burst),
        .hold_id(hold_id),
        .hold_get_next_data(hold_get_next_data),
        .split_err(split_err),
`ifdef DWC_DOWNCONV_WR_BCNT_EN
        .bcnt_push(bcnt_push),
        .bcnt_data(bcnt_data),
`endif
        .SLAVE(slvAw.master)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        id;
        logic        last;
        int          bcnt;
    } aw_t;

    aw_t expQ[$];
    int  nChecks = 0;
    int  nFails  = 0;
    int  gnCnt   = 0;
    int  seCnt   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic aw_t mkAw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                 input logic [1:0] b, input logic i);
        aw_t x;
        x.addr = a; x.len = l; x.size = s; x.burst = b; x.id = i; x.last = 1'b0; x.bcnt = 0;
        return x;
    endfunction

    // Reference model: 64-bit master, 32-bit slave, 256-beat chunks of 1 KiB.
    task automatic pushExpected(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst, input logic id);
        aw_t t[$];
        int ratio = (size > 3'd2) ? int'(size) - 2 : 0;
        int total;
        logic [31:0] base;
        if (ratio == 0) t.push_back(mkAw(addr, len, size, burst, id));
        else begin
            base = addr & ~((32'd1 << size) - 32'd1);
            if (burst == 2'b00) begin
                for (int i = 0; i <= int'(len); i++) t.push_back(mkAw(base, 8'((1 << ratio) - 1), 3'd2, 2'd1, id));
            end else begin
                total = (int'(len) + 1) << ratio;
                for (int k = 0; total > 0; k++) begin
                    int c = (total > 256) ? 256 : total;
                    t.push_back(mkAw(base + 32'(k * 1024), 8'(c - 1), 3'd2, 2'd1, id));
                    total -= c;
                end
            end
        end
        t[t.size() - 1].last = 1'b1;
        t[t.size() - 1].bcnt = t.size();
        foreach (t[i]) expQ.push_back(t[i]);
    endtask

    logic        stallSeen = 1'b0;
    logic [31:0] stAddr;
    logic [7:0]  stLen;
    logic [2:0]  stSize;
    logic [1:0]  stBurst;

    always @(negedge ACLK) begin : monitor
        aw_t e;
        if (sysReset) stallSeen = 1'b0;
        else begin
            if (hold_get_next_data) gnCnt++;
            if (split_err) seCnt++;
            if (stallSeen) begin
                check("valid_held", slvAw.AWVALID, 1'b1);
                check("stall_addr", slvAw.AWADDR, stAddr);
                check("stall_len", slvAw.AWLEN, stLen);
                check("stall_size", slvAw.AWSIZE, stSize);
                check("stall_burst", slvAw.AWBURST, stBurst);
            end
            if (slvAw.AWVALID && slvAw.AWREADY) begin
                if (expQ.size() == 0) check("unexpected_aw", 1'b1, 1'b0);
                else begin
                    e = expQ.pop_front();
                    check("awaddr", slvAw.AWADDR, e.addr);
                    check("awlen", slvAw.AWLEN, e.len);
                    check("awsize", slvAw.AWSIZE, e.size);
                    check("awburst", slvAw.AWBURST, e.burst);
                    check("awid", slvAw.AWID, e.id);
                    check("get_next", hold_get_next_data, e.last);
`ifdef DWC_DOWNCONV_WR_BCNT_EN
                    check("bcnt_push", bcnt_push, e.last);
                    if (e.last) check("bcnt_data", bcnt_data, 64'(e.bcnt));
`endif
                end
            end else if (hold_get_next_data) check("get_next_no_handshake", hold_get_next_data, 1'b0);
            stallSeen = slvAw.AWVALID && !slvAw.AWREADY;
            stAddr = slvAw.AWADDR; stLen = slvAw.AWLEN; stSize = slvAw.AWSIZE; stBurst = slvAw.AWBURST;
        end
    end

    task automatic startCmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic i);
        gnCnt = 0; seCnt = 0;
        pushExpected(a, l, s, b, i);
        hold_addr = a; hold_len = l; hold_size = s; hold_burst = b; hold_id = i;
        hold_valid = 1'b1;
    endtask

    task automatic waitValid();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge ACLK); #1;
            seen = slvAw.AWVALID;
        end
        check("valid_rise", seen, 1'b1);
    endtask

    task automatic finishCmd(input int expSplit);
        bit done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge ACLK);
            done = hold_get_next_data;
        end
        check("get_next_seen", done, 1'b1);
        @(posedge ACLK); #1;
        hold_valid = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("get_next_count", 64'(gnCnt), 64'd1);
        check("split_err_count", 64'(seCnt), 64'(expSplit));
        check("queue_empty", 64'(expQ.size()), 64'd0);
        check("idle_valid", slvAw.AWVALID, 1'b0);
        expQ.delete();
    endtask

    task automatic runCmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic i, input int stall, input int expSplit);
        if (stall > 0) slvAw.AWREADY = 1'b0;
        startCmd(a, l, s, b, i);
        if (stall > 0) begin
            waitValid();
            repeat (stall) @(posedge ACLK);
            #1;
            slvAw.AWREADY = 1'b1;
        end
        finishCmd(expSplit);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rs;
        logic [1:0] rb;
        slvAw.AWREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_valid", slvAw.AWVALID, 1'b0);
        check("rst_get_next", hold_get_next_data, 1'b0);
        check("rst_split_err", split_err, 1'b0);
        check("rst_awaddr", slvAw.AWADDR, 32'd0);
        check("rst_awlen", slvAw.AWLEN, 8'd0);
        check("rst_awsize", slvAw.AWSIZE, 3'd0);
        check("rst_awburst", slvAw.AWBURST, 2'd0);
        check("rst_awid", slvAw.AWID, 1'b0);
`ifdef DWC_DOWNCONV_WR_BCNT_EN
        check("rst_bcnt_push", bcnt_push, 1'b0);
        check("rst_bcnt_data", bcnt_data, 9'd0);
`endif
        sysReset = 1'b0;
        @(posedge ACLK); #1;

        runCmd(32'h1000, 8'd3,   3'd3, 2'd1, 1'b0, 0, 0);   // one chunk
        runCmd(32'h2000, 8'd255, 3'd3, 2'd1, 1'b1, 0, 0);   // two chunks
        runCmd(32'h2000, 8'd255, 3'd3, 2'd1, 1'b0, 5, 0);   // stall on first chunk
        runCmd(32'h3004, 8'd2,   3'd3, 2'd0, 1'b1, 0, 0);   // FIXED split
        runCmd(32'h0010, 8'd3,   3'd2, 2'd2, 1'b0, 0, 0);   // WRAP passthrough
        runCmd(32'h0040, 8'd1,   3'd3, 2'd2, 1'b0, 0, 1);   // WRAP needing split
        runCmd(32'h0103, 8'd0,   3'd1, 2'd1, 1'b1, 0, 0);   // narrow unaligned passthrough
        runCmd(32'h5000, 8'd0,   3'd3, 2'd0, 1'b0, 2, 0);   // single-beat FIXED, stalled

        for (int n = 0; n < 8; n++) begin
            rs = 3'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 2));
            runCmd($urandom, 8'($urandom_range(0, 255)), rs, rb, 1'($urandom),
                   int'($urandom_range(0, 3)), (rb == 2'd2 && rs > 3'd2) ? 1 : 0);
        end

        // Reset while a burst is pending, with READY asserted during reset.
        slvAw.AWREADY = 1'b0;
        startCmd(32'h2000, 8'd255, 3'd3, 2'd1, 1'b1);
        waitValid();
        #2;
        sysReset = 1'b1;
        #1;
        check("midrst_valid", slvAw.AWVALID, 1'b0);
        check("midrst_get_next", hold_get_next_data, 1'b0);
        expQ.delete();
        slvAw.AWREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check("midrst_valid_ready", slvAw.AWVALID, 1'b0);
        check("midrst_get_next_ready", hold_get_next_data, 1'b0);
        sysReset = 1'b0;
        gnCnt = 0; seCnt = 0;
        pushExpected(32'h2000, 8'd255, 3'd3, 2'd1, 1'b1);
        finishCmd(0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
